// File: rtl/data_memory_be.sv
// Two-write/two-read data memory with byte enables, port-2-wins collision merge,
// selectable read-during-write, range checking and a post-reset zero-fill sweep.
module data_memory_be #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  output logic                    ready,
  input  logic                    wr_en1,
  input  logic                    wr_en2,
  input  logic [DATA_WIDTH/8-1:0] wr_be1,
  input  logic [DATA_WIDTH/8-1:0] wr_be2,
  input  logic [ADDR_WIDTH-1:0]   wr_addr1,
  input  logic [ADDR_WIDTH-1:0]   wr_addr2,
  input  logic [DATA_WIDTH-1:0]   data_in1,
  input  logic [DATA_WIDTH-1:0]   data_in2,
  input  logic                    rd_en1,
  input  logic                    rd_en2,
  input  logic [ADDR_WIDTH-1:0]   rd_addr1,
  input  logic [ADDR_WIDTH-1:0]   rd_addr2,
  output logic [DATA_WIDTH-1:0]   data_out1,
  output logic [DATA_WIDTH-1:0]   data_out2,
  output logic                    rd_valid1,
  output logic                    rd_valid2,
  output logic                    wr_collision,
  output logic                    addr_err
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   init_cnt_q;
  logic                    ready_q;
  logic [DATA_WIDTH-1:0]   data_out1_q, data_out2_q;
  logic                    rd_valid1_q, rd_valid2_q;
  logic                    wr_collision_q, addr_err_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic wr_in1, wr_in2, rd_in1, rd_in2;
  logic w1_ok, w2_ok, collision, range_err;
  logic [DATA_WIDTH-1:0] wr_word1, wr_word2, rd_word1, rd_word2;

  // Applies both ports' enabled bytes onto a word at addr; port 2 is applied last so it wins.
  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] word,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  w1,
    input logic [ADDR_WIDTH-1:0] a1,
    input logic [NB-1:0]         be1,
    input logic [DATA_WIDTH-1:0] d1,
    input logic                  w2,
    input logic [ADDR_WIDTH-1:0] a2,
    input logic [NB-1:0]         be2,
    input logic [DATA_WIDTH-1:0] d2
  );
    logic [DATA_WIDTH-1:0] res;
    res = word;
    for (int b = 0; b < NB; b++) begin
      if (w1 && (a1 == addr) && be1[b]) res[8*b +: 8] = d1[8*b +: 8];
      if (w2 && (a2 == addr) && be2[b]) res[8*b +: 8] = d2[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    wr_in1    = 32'(wr_addr1) < DEPTH;
    wr_in2    = 32'(wr_addr2) < DEPTH;
    rd_in1    = 32'(rd_addr1) < DEPTH;
    rd_in2    = 32'(rd_addr2) < DEPTH;
    w1_ok     = ready_q && wr_en1 && wr_in1;
    w2_ok     = ready_q && wr_en2 && wr_in2;
    collision = w1_ok && w2_ok && (wr_addr1 == wr_addr2) && |(wr_be1 & wr_be2);
    range_err = (wr_en1 && !wr_in1) || (wr_en2 && !wr_in2) ||
                (rd_en1 && !rd_in1) || (rd_en2 && !rd_in2);

    wr_word1 = '0;
    wr_word2 = '0;
    if (w1_ok) begin
      wr_word1 = merge_word(mem_q[wr_addr1], wr_addr1, w1_ok, wr_addr1, wr_be1, data_in1,
                            w2_ok, wr_addr2, wr_be2, data_in2);
    end
    if (w2_ok) begin
      wr_word2 = merge_word(mem_q[wr_addr2], wr_addr2, w1_ok, wr_addr1, wr_be1, data_in1,
                            w2_ok, wr_addr2, wr_be2, data_in2);
    end

    rd_word1 = '0;
    rd_word2 = '0;
    if (rd_in1) begin
      rd_word1 = mem_q[rd_addr1];
      if (RDW_MODE != 0) begin
        rd_word1 = merge_word(rd_word1, rd_addr1, w1_ok, wr_addr1, wr_be1, data_in1,
                              w2_ok, wr_addr2, wr_be2, data_in2);
      end
    end
    if (rd_in2) begin
      rd_word2 = mem_q[rd_addr2];
      if (RDW_MODE != 0) begin
        rd_word2 = merge_word(rd_word2, rd_addr2, w1_ok, wr_addr1, wr_be1, data_in1,
                              w2_ok, wr_addr2, wr_be2, data_in2);
      end
    end
  end

  // Storage carries no reset; the INIT sweep defines its contents.
  always_ff @(posedge clk) begin
    if (!ready_q) begin
      mem_q[init_cnt_q] <= '0;
    end else begin
      if (w1_ok) mem_q[wr_addr1] <= wr_word1;
      if (w2_ok) mem_q[wr_addr2] <= wr_word2;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= StInit;
      init_cnt_q     <= '0;
      ready_q        <= 1'b0;
      data_out1_q    <= '0;
      data_out2_q    <= '0;
      rd_valid1_q    <= 1'b0;
      rd_valid2_q    <= 1'b0;
      wr_collision_q <= 1'b0;
      addr_err_q     <= 1'b0;
    end else begin
      rd_valid1_q    <= 1'b0;
      rd_valid2_q    <= 1'b0;
      wr_collision_q <= 1'b0;
      addr_err_q     <= 1'b0;
      case (state_q)
        StInit: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == LastAddr) begin
            state_q <= StReady;
            ready_q <= 1'b1;
          end
        end
        StReady: begin
          rd_valid1_q    <= rd_en1;
          rd_valid2_q    <= rd_en2;
          if (rd_en1) data_out1_q <= rd_word1;
          if (rd_en2) data_out2_q <= rd_word2;
          wr_collision_q <= collision;
          addr_err_q     <= range_err;
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign ready        = ready_q;
  assign data_out1    = data_out1_q;
  assign data_out2    = data_out2_q;
  assign rd_valid1    = rd_valid1_q;
  assign rd_valid2    = rd_valid2_q;
  assign wr_collision = wr_collision_q;
  assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_data_memory_be.sv
// Bench for data_memory_be: two instances (DEPTH 8 / old-data RDW, DEPTH 6 / forwarding RDW)
// driven by shared stimulus and checked against a word-array reference model.
module tb_data_memory_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;
  logic        wr_en1, wr_en2, rd_en1, rd_en2;
  logic [3:0]  wr_be1, wr_be2;
  logic [2:0]  wr_addr1, wr_addr2, rd_addr1, rd_addr2;
  logic [31:0] data_in1, data_in2;

  logic [1:0]       rdy, v1, v2, col, aerr;
  logic [1:0][31:0] dout1, dout2;

  data_memory_be #(.DEPTH(8), .DATA_WIDTH(32), .ADDR_WIDTH(3), .RDW_MODE(0)) u_dut_old (
    .clk(clk), .rstn(rstn), .ready(rdy[0]),
    .wr_en1(wr_en1), .wr_en2(wr_en2), .wr_be1(wr_be1), .wr_be2(wr_be2),
    .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .data_in1(data_in1), .data_in2(data_in2),
    .rd_en1(rd_en1), .rd_en2(rd_en2), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .data_out1(dout1[0]), .data_out2(dout2[0]), .rd_valid1(v1[0]), .rd_valid2(v2[0]),
    .wr_collision(col[0]), .addr_err(aerr[0])
  );

  data_memory_be #(.DEPTH(6), .DATA_WIDTH(32), .ADDR_WIDTH(3), .RDW_MODE(1)) u_dut_new (
    .clk(clk), .rstn(rstn), .ready(rdy[1]),
    .wr_en1(wr_en1), .wr_en2(wr_en2), .wr_be1(wr_be1), .wr_be2(wr_be2),
    .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .data_in1(data_in1), .data_in2(data_in2),
    .rd_en1(rd_en1), .rd_en2(rd_en2), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .data_out1(dout1[1]), .data_out2(dout2[1]), .rd_valid1(v1[1]), .rd_valid2(v2[1]),
    .wr_collision(col[1]), .addr_err(aerr[1])
  );

  // Reference model state, one slot per instance.
  logic [31:0] mdl [2][8];
  int          sweep_cnt [2];
  bit          mdl_rdy [2];
  logic [31:0] exp_d1 [2], exp_d2 [2];
  bit          exp_v1 [2], exp_v2 [2], exp_col [2], exp_err [2];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int depth_of(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en1 = 0; wr_en2 = 0; rd_en1 = 0; rd_en2 = 0;
    wr_be1 = '0; wr_be2 = '0;
    wr_addr1 = '0; wr_addr2 = '0; rd_addr1 = '0; rd_addr2 = '0;
    data_in1 = '0; data_in2 = '0;
  endtask

  task automatic rand_inputs();
    wr_en1   = 1'($urandom_range(0, 1));
    wr_en2   = 1'($urandom_range(0, 1));
    rd_en1   = 1'($urandom_range(0, 1));
    rd_en2   = 1'($urandom_range(0, 1));
    wr_be1   = 4'($urandom);
    wr_be2   = 4'($urandom);
    data_in1 = $urandom;
    data_in2 = $urandom;
    wr_addr1 = 3'($urandom_range(0, 7));
    wr_addr2 = ($urandom_range(0, 2) == 0) ? wr_addr1 : 3'($urandom_range(0, 7));
    rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr1 : 3'($urandom_range(0, 7));
    rd_addr2 = ($urandom_range(0, 2) == 0) ? wr_addr2 : 3'($urandom_range(0, 7));
  endtask

  // Predicts the state after the coming clock edge from the current inputs.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int          dep;
      bit          w1, w2;
      logic [31:0] nw [8];
      dep = depth_of(k);
      exp_v1[k] = 0; exp_v2[k] = 0; exp_col[k] = 0; exp_err[k] = 0;
      if (!mdl_rdy[k]) begin
        sweep_cnt[k]++;
        if (sweep_cnt[k] == dep) begin
          mdl_rdy[k] = 1;
          for (int i = 0; i < 8; i++) mdl[k][i] = '0;
        end
      end else begin
        w1 = wr_en1 && (int'(wr_addr1) < dep);
        w2 = wr_en2 && (int'(wr_addr2) < dep);
        for (int i = 0; i < 8; i++) nw[i] = mdl[k][i];
        for (int b = 0; b < 4; b++) begin
          if (w1 && wr_be1[b]) nw[wr_addr1][8*b +: 8] = data_in1[8*b +: 8];
        end
        for (int b = 0; b < 4; b++) begin
          if (w2 && wr_be2[b]) nw[wr_addr2][8*b +: 8] = data_in2[8*b +: 8];
        end
        exp_col[k] = w1 && w2 && (wr_addr1 == wr_addr2) && ((wr_be1 & wr_be2) != 0);
        exp_err[k] = (wr_en1 && int'(wr_addr1) >= dep) || (wr_en2 && int'(wr_addr2) >= dep) ||
                     (rd_en1 && int'(rd_addr1) >= dep) || (rd_en2 && int'(rd_addr2) >= dep);
        if (rd_en1) begin
          exp_v1[k] = 1;
          exp_d1[k] = (int'(rd_addr1) >= dep) ? 32'h0 : (k == 1) ? nw[rd_addr1] : mdl[k][rd_addr1];
        end
        if (rd_en2) begin
          exp_v2[k] = 1;
          exp_d2[k] = (int'(rd_addr2) >= dep) ? 32'h0 : (k == 1) ? nw[rd_addr2] : mdl[k][rd_addr2];
        end
        for (int i = 0; i < 8; i++) mdl[k][i] = nw[i];
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("ready[%0d]", k), 32'(rdy[k]), 32'(mdl_rdy[k]));
      check_eq($sformatf("rd_valid1[%0d]", k), 32'(v1[k]), 32'(exp_v1[k]));
      check_eq($sformatf("rd_valid2[%0d]", k), 32'(v2[k]), 32'(exp_v2[k]));
      check_eq($sformatf("data_out1[%0d]", k), dout1[k], exp_d1[k]);
      check_eq($sformatf("data_out2[%0d]", k), dout2[k], exp_d2[k]);
      check_eq($sformatf("wr_collision[%0d]", k), 32'(col[k]), 32'(exp_col[k]));
      check_eq($sformatf("addr_err[%0d]", k), 32'(aerr[k]), 32'(exp_err[k]));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mdl_rdy[k] = 0; sweep_cnt[k] = 0;
      exp_d1[k] = '0; exp_d2[k] = '0;
      exp_v1[k] = 0; exp_v2[k] = 0; exp_col[k] = 0; exp_err[k] = 0;
    end
  endtask

  // Called just after an edge: asserts reset mid-cycle and checks outputs clear at once.
  task automatic async_reset();
    idle();
    rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    check_all();
    rstn = 1'b1;

    // Sweep with random strobes that must be ignored.
    for (int i = 0; i < 8; i++) begin
      rand_inputs();
      cycle();
    end
    for (int i = 0; i < 8; i++) begin
      idle(); rd_en1 = 1; rd_addr1 = 3'(i); rd_en2 = 1; rd_addr2 = 3'(7 - i);
      cycle();
    end

    // Byte enables.
    idle(); wr_en1 = 1; wr_addr1 = 3'd1; data_in1 = 32'hAABBCCDD; wr_be1 = 4'hF; cycle();
    idle(); wr_en1 = 1; wr_addr1 = 3'd1; data_in1 = 32'h11223344; wr_be1 = 4'b0101; cycle();
    idle(); rd_en1 = 1; rd_addr1 = 3'd1; cycle();
    check_eq("be_merge_old", dout1[0], 32'hAA22CC44);
    check_eq("be_merge_new", dout1[1], 32'hAA22CC44);

    // Collision.
    idle();
    wr_en1 = 1; wr_addr1 = 3'd3; data_in1 = 32'hFFFF0000; wr_be1 = 4'b1111;
    wr_en2 = 1; wr_addr2 = 3'd3; data_in2 = 32'h12345678; wr_be2 = 4'b0011;
    cycle();
    check_eq("collision_flag_old", 32'(col[0]), 32'd1);
    check_eq("collision_flag_new", 32'(col[1]), 32'd1);
    idle(); rd_en2 = 1; rd_addr2 = 3'd3; cycle();
    check_eq("collision_data_old", dout2[0], 32'hFFFF5678);
    check_eq("collision_data_new", dout2[1], 32'hFFFF5678);
    check_eq("collision_flag_clear", 32'(col[0]), 32'd0);

    // Read-during-write.
    idle(); wr_en1 = 1; wr_addr1 = 3'd2; data_in1 = 32'd5; wr_be1 = 4'hF; cycle();
    idle(); wr_en1 = 1; wr_addr1 = 3'd2; data_in1 = 32'd9; wr_be1 = 4'hF;
    rd_en1 = 1; rd_addr1 = 3'd2; cycle();
    check_eq("rdw_old_data", dout1[0], 32'd5);
    check_eq("rdw_new_data", dout1[1], 32'd9);
    idle(); rd_en1 = 1; rd_addr1 = 3'd2; rd_en2 = 1; rd_addr2 = 3'd2; cycle();
    check_eq("rdw_after_old", dout1[0], 32'd9);
    check_eq("dual_read_new", dout2[1], 32'd9);

    // Out of range on the DEPTH 6 instance.
    idle(); wr_en1 = 1; wr_addr1 = 3'd6; data_in1 = 32'd7; wr_be1 = 4'hF; cycle();
    check_eq("range_wr_err_new", 32'(aerr[1]), 32'd1);
    check_eq("range_wr_err_old", 32'(aerr[0]), 32'd0);
    idle(); rd_en1 = 1; rd_addr1 = 3'd6; cycle();
    check_eq("range_rd_data_new", dout1[1], 32'd0);
    check_eq("range_rd_valid_new", 32'(v1[1]), 32'd1);
    check_eq("range_rd_err_new", 32'(aerr[1]), 32'd1);
    check_eq("range_rd_data_old", dout1[0], 32'd7);
    idle(); cycle();

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle();
    end

    // Reset mid-operation, then mid-sweep at sweep cycle 4.
    async_reset();
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      cycle();
    end
    async_reset();
    for (int i = 0; i < 8; i++) begin
      rand_inputs();
      cycle();
    end
    check_eq("ready_after_resweep", 32'(rdy[0]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      idle(); rd_en1 = 1; rd_addr1 = 3'(i); rd_en2 = 1; rd_addr2 = 3'(i);
      cycle();
    end
    for (int i = 0; i < 100; i++) begin
      rand_inputs();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
